chart_sequencer: RTL and testbench

- Parametrised successor to the fixed per-section note-chart modules: a chart RAM plus a step sequencer that emits the expected fret pattern for each eighth-beat step.
- The chart is written at runtime, so one instance serves verse, chorus and bridge.
- Adds programmable length, one-shot/loop mode, start/stop control, a step index, a loop counter and note/done strobes.
- Sits between the beat generator and the hit-judging/display logic.

---
 rtl/sequencer_pkg.sv | 18 +
 rtl/chart_ram.sv | 30 +++
 rtl/chart_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_chart_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sequencer_pkg.sv
// Shared types and constants for the chart sequencer slice.
// Chord constants name the common power-chord fret patterns used by chart authors.
package sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_PLAY  = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  localparam int DEFAULT_LANES = 5;

  localparam logic [DEFAULT_LANES-1:0] CHORD_A5   = 5'b00111;
  localparam logic [DEFAULT_LANES-1:0] CHORD_G5   = 5'b01011;
  localparam logic [DEFAULT_LANES-1:0] CHORD_REST = '0;

endpackage

// File: rtl/chart_ram.sv
// Single-clock chart storage: one write port, one synchronous read port.
// Read-first: a same-edge write to the read address returns the previous contents.
module chart_ram
  import sequencer_pkg::*;
#(
  parameter int LANES = DEFAULT_LANES,
  parameter int STEPS = 128,
  localparam int AW   = $clog2(STEPS)
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [LANES-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [LANES-1:0] o_rd_data
);

  logic [LANES-1:0] r_mem [STEPS];
  logic [LANES-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/chart_sequencer.sv
// Runtime-programmable note chart with an eighth-beat step sequencer.
// Each accepted tick travels a two-stage pipeline so step, exp_notes and note_valid land together.
module chart_sequencer
  import sequencer_pkg::*;
#(
  parameter int LANES  = DEFAULT_LANES,
  parameter int STEPS  = 128,
  parameter int STEP_W = $clog2(STEPS),
  parameter int LOOP_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              beat_tick,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_mode,
  input  logic [STEP_W-1:0] last_step,
  input  logic              wr_en,
  input  logic [STEP_W-1:0] wr_addr,
  input  logic [LANES-1:0]  wr_data,
  output logic [LANES-1:0]  exp_notes,
  output logic              note_valid,
  output logic [STEP_W-1:0] step,
  output logic              playing,
  output logic              done,
  output logic [LOOP_W-1:0] loop_count
);

  seq_state_t        r_state;
  seq_state_t        w_next_state;
  logic [STEP_W-1:0] r_cur;
  logic [STEP_W-1:0] w_next_cur;
  logic [LOOP_W-1:0] r_loop_cnt;
  logic              w_loop_inc;

  logic              w_issue;
  logic              w_issue_fin;
  logic [STEP_W-1:0] w_issue_addr;
  logic              w_flush;
  logic [STEP_W-1:0] w_last_eff;
  logic              w_at_end;

  logic              r_s1_valid;
  logic              r_s1_fin;
  logic [STEP_W-1:0] r_s1_addr;
  logic              r_s2_valid;
  logic              r_s2_fin;
  logic [STEP_W-1:0] r_s2_addr;
  logic [LANES-1:0]  w_rd_data;

  logic [LANES-1:0]  r_exp;
  logic              r_note_valid;
  logic [STEP_W-1:0] r_step;
  logic              r_done;

  logic              w_wr_en;

  assign w_wr_en    = wr_en & resetn;
  assign w_flush    = stop | start;
  assign w_last_eff = (last_step > STEP_W'(STEPS - 1)) ? STEP_W'(STEPS - 1) : last_step;
  // A last_step already behind the play position counts as reached.
  assign w_at_end   = (r_cur >= w_last_eff);

  chart_ram #(
    .LANES (LANES),
    .STEPS (STEPS)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_addr (r_s1_addr),
    .o_rd_data (w_rd_data)
  );

  always_comb begin
    w_next_state = r_state;
    w_next_cur   = r_cur;
    w_loop_inc   = 1'b0;
    w_issue      = 1'b0;
    w_issue_fin  = 1'b0;
    w_issue_addr = '0;
    if (stop) begin
      w_next_state = ST_IDLE;
      w_next_cur   = '0;
    end else if (start) begin
      w_next_state = ST_ARMED;
      w_next_cur   = '0;
    end else if (beat_tick) begin
      case (r_state)
        ST_ARMED: begin
          w_next_state = ST_PLAY;
          w_next_cur   = '0;
          w_issue      = 1'b1;
        end
        ST_PLAY: begin
          if (!w_at_end) begin
            w_next_cur   = r_cur + STEP_W'(1);
            w_issue      = 1'b1;
            w_issue_addr = r_cur + STEP_W'(1);
          end else if (loop_mode) begin
            w_next_cur = '0;
            w_loop_inc = 1'b1;
            w_issue    = 1'b1;
          end else begin
            w_next_state = ST_DONE;
            w_issue      = 1'b1;
            w_issue_fin  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_cur      <= '0;
      r_loop_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      r_cur   <= w_next_cur;
      if (start && !stop) begin
        r_loop_cnt <= '0;
      end else if (w_loop_inc && (r_loop_cnt != '1)) begin
        r_loop_cnt <= r_loop_cnt + LOOP_W'(1);
      end
    end
  end

  // Stage 1 holds the issued RAM address; stage 2 lines up with the RAM output.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s1_valid <= 1'b0;
      r_s1_fin   <= 1'b0;
      r_s1_addr  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_fin   <= 1'b0;
      r_s2_addr  <= '0;
    end else if (w_flush) begin
      r_s1_valid <= 1'b0;
      r_s1_fin   <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_fin   <= 1'b0;
    end else begin
      r_s1_valid <= w_issue;
      r_s1_fin   <= w_issue_fin;
      r_s1_addr  <= w_issue_addr;
      r_s2_valid <= r_s1_valid;
      r_s2_fin   <= r_s1_fin;
      r_s2_addr  <= r_s1_addr;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_exp        <= '0;
      r_note_valid <= 1'b0;
      r_step       <= '0;
      r_done       <= 1'b0;
    end else if (w_flush) begin
      r_exp        <= '0;
      r_note_valid <= 1'b0;
      r_step       <= '0;
      r_done       <= 1'b0;
    end else if (r_s2_valid && r_s2_fin) begin
      r_exp        <= '0;
      r_note_valid <= 1'b0;
      r_done       <= 1'b1;
    end else if (r_s2_valid) begin
      r_exp        <= w_rd_data;
      r_note_valid <= |w_rd_data;
      r_step       <= r_s2_addr;
      r_done       <= 1'b0;
    end else begin
      r_note_valid <= 1'b0;
      r_done       <= 1'b0;
    end
  end

  assign exp_notes  = r_exp;
  assign note_valid = r_note_valid;
  assign step       = r_step;
  assign playing    = (r_state == ST_ARMED) || (r_state == ST_PLAY);
  assign done       = r_done;
  assign loop_count = r_loop_cnt;

endmodule

// File: tb/tb_chart_sequencer.sv
// Self-checking bench for chart_sequencer: directed chart scenarios plus random traffic
// compared every cycle against a tick-queue reference model.
module tb_chart_sequencer;
  import sequencer_pkg::*;

  localparam int LANES  = 5;
  localparam int STEPS  = 8;
  localparam int STEP_W = 3;
  localparam int LOOP_W = 8;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_PLAY  = 2;
  localparam int M_DONE  = 3;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              beat_tick = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              loop_mode = 1'b0;
  logic [STEP_W-1:0] last_step = '0;
  logic              wr_en = 1'b0;
  logic [STEP_W-1:0] wr_addr = '0;
  logic [LANES-1:0]  wr_data = '0;
  logic [LANES-1:0]  exp_notes;
  logic              note_valid;
  logic [STEP_W-1:0] step;
  logic              playing;
  logic              done;
  logic [LOOP_W-1:0] loop_count;

  chart_sequencer #(
    .LANES  (LANES),
    .STEPS  (STEPS),
    .LOOP_W (LOOP_W)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .beat_tick  (beat_tick),
    .start      (start),
    .stop       (stop),
    .loop_mode  (loop_mode),
    .last_step  (last_step),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .exp_notes  (exp_notes),
    .note_valid (note_valid),
    .step       (step),
    .playing    (playing),
    .done       (done),
    .loop_count (loop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               due;
    bit               fin;
    int               addr;
    logic [LANES-1:0] data;
  } pend_t;

  pend_t            pq[$];
  logic [LANES-1:0] chart [STEPS];
  int               cyc = 0;
  int               mState = M_IDLE;
  int               mPos = 0;
  int               mLoops = 0;
  int               mStep = 0;
  logic [LANES-1:0] mExp = '0;
  bit               mNv = 1'b0;
  bit               mDone = 1'b0;

  int total = 0;
  int bad = 0;
  int nvCount = 0;
  int doneCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, expv);
    end
  endtask

  function automatic void pushTick(input bit fin, input int addr);
    pend_t p;
    p.due  = cyc + 2;
    p.fin  = fin;
    p.addr = addr;
    p.data = '0;
    pq.push_back(p);
  endfunction

  // Reference: a tick accepted at edge N is read from the chart at N+1 and shown at N+2.
  function automatic void modelEdge();
    pend_t p;
    mNv   = 1'b0;
    mDone = 1'b0;
    foreach (pq[i]) begin
      if (pq[i].due == cyc + 1) pq[i].data = chart[pq[i].addr];
    end
    if (wr_en) chart[wr_addr] = wr_data;
    if (stop || start) begin
      pq.delete();
      mExp  = '0;
      mStep = 0;
      if (stop) begin
        mState = M_IDLE;
      end else begin
        mState = M_ARMED;
        mPos   = 0;
        mLoops = 0;
      end
      return;
    end
    if (pq.size() > 0 && pq[0].due == cyc) begin
      p = pq.pop_front();
      if (p.fin) begin
        mExp  = '0;
        mDone = 1'b1;
      end else begin
        mExp  = p.data;
        mNv   = (p.data != '0);
        mStep = p.addr;
      end
    end
    if (beat_tick) begin
      if (mState == M_ARMED) begin
        mState = M_PLAY;
        mPos   = 0;
        pushTick(1'b0, 0);
      end else if (mState == M_PLAY) begin
        if (mPos >= int'(last_step)) begin
          if (loop_mode) begin
            mPos = 0;
            if (mLoops < 255) mLoops++;
            pushTick(1'b0, 0);
          end else begin
            mState = M_DONE;
            pushTick(1'b1, 0);
          end
        end else begin
          mPos++;
          pushTick(1'b0, mPos);
        end
      end
    end
  endfunction

  task automatic runCycle();
    @(posedge clk);
    cyc++;
    modelEdge();
    #1;
    checkOutput("exp_notes", exp_notes, mExp);
    checkOutput("note_valid", note_valid, mNv);
    checkOutput("step", step, mStep);
    checkOutput("done", done, mDone);
    checkOutput("playing", playing, (mState == M_ARMED || mState == M_PLAY));
    checkOutput("loop_count", loop_count, mLoops);
    if (note_valid === 1'b1) nvCount++;
    if (done === 1'b1) doneCount++;
    beat_tick = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    wr_en     = 1'b0;
  endtask

  task automatic applyStimulus(input bit tick, input bit st, input bit sp,
                               input bit we, input int wa, input logic [LANES-1:0] wd);
    logic [31:0] a;
    a         = wa;
    beat_tick = tick;
    start     = st;
    stop      = sp;
    wr_en     = we;
    wr_addr   = a[STEP_W-1:0];
    wr_data   = wd;
    runCycle();
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, '0);
  endtask

  task automatic tickWait(input int n);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, '0);
    idle(n);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_exp"}, exp_notes, 0);
    checkOutput({tag, "_nv"}, note_valid, 0);
    checkOutput({tag, "_step"}, step, 0);
    checkOutput({tag, "_playing"}, playing, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_loops"}, loop_count, 0);
  endtask

  // Asserts reset away from any clock edge; a write held during reset must not land.
  task automatic midReset();
    #2;
    resetn  = 1'b0;
    wr_en   = 1'b1;
    wr_addr = '0;
    wr_data = 5'b11000;
    #1;
    checkAllZero("async_reset");
    pq.delete();
    mState = M_IDLE;
    mPos   = 0;
    mLoops = 0;
    mStep  = 0;
    mExp   = '0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    wr_en  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [LANES-1:0] pattern [STEPS];
    pattern = '{CHORD_A5, CHORD_REST, CHORD_A5, CHORD_G5, CHORD_A5,
                CHORD_REST, CHORD_REST, CHORD_REST};

    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    resetn = 1'b1;

    for (int i = 0; i < STEPS; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, i, pattern[i]);

    // One-shot chart of five steps.
    last_step = 3'd4;
    loop_mode = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, '0);
    nvCount   = 0;
    doneCount = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, '0);
    idle(1);
    checkOutput("oneshot_lat_n1", exp_notes, 0);
    idle(1);
    checkOutput("oneshot_lat_n2", exp_notes, CHORD_A5);
    idle(5);
    repeat (5) tickWait(7);
    checkOutput("oneshot_nv_pulses", nvCount, 4);
    checkOutput("oneshot_done_pulses", doneCount, 1);
    checkOutput("oneshot_playing", playing, 0);

    // Looping chart: 11 ticks wrap twice.
    loop_mode = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, '0);
    doneCount = 0;
    repeat (11) tickWait(4);
    checkOutput("loop_count_2", loop_count, 2);
    checkOutput("loop_no_done", doneCount, 0);

    // Write to step 3 on the edge where step 3 is read.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, '0);
    repeat (3) tickWait(3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3, 5'b10001);
    idle(1);
    checkOutput("rf_old_data", exp_notes, CHORD_G5);
    checkOutput("rf_old_step", step, 3);
    idle(1);
    repeat (4) tickWait(3);
    tickWait(2);
    checkOutput("rf_new_data", exp_notes, 5'b10001);

    // Back-to-back ticks over the full depth.
    last_step = 3'd7;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, '0);
    repeat (20) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, '0);
    idle(3);
    checkOutput("b2b_loops", loop_count, 2);

    // stop together with a tick while another tick is still in flight.
    last_step = 3'd4;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, '0);
    repeat (2) tickWait(3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, '0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 0, '0);
    nvCount   = 0;
    doneCount = 0;
    idle(4);
    checkOutput("stop_nv", nvCount, 0);
    checkOutput("stop_done", doneCount, 0);
    checkOutput("stop_exp", exp_notes, 0);

    // Reset during playback; chart must survive.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, '0);
    repeat (2) tickWait(3);
    midReset();
    checkAllZero("post_reset");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, '0);
    tickWait(2);
    checkOutput("retained_entry0", exp_notes, CHORD_A5);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit tk, st, sp, we;
      if ($urandom_range(0, 49) == 0) loop_mode = $urandom_range(0, 1);
      if ($urandom_range(0, 39) == 0) last_step = STEP_W'($urandom_range(0, STEPS - 1));
      tk = ($urandom_range(0, 2) == 0);
      we = ($urandom_range(0, 5) == 0);
      sp = ($urandom_range(0, 89) == 0);
      if (mState == M_IDLE || mState == M_DONE) st = ($urandom_range(0, 9) == 0);
      else st = ($urandom_range(0, 69) == 0);
      applyStimulus(tk, st, sp, we, $urandom_range(0, STEPS - 1),
                    LANES'($urandom_range(0, (1 << LANES) - 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
